pipe_mux_skid: RTL and testbench

//  Parametrised N:1 operand/forwarding select with a registered 2-entry skid stage.

---
 rtl/pipe_mux_skid.sv | 123 ++++++++++++
 tb/tb_pipe_mux_skid.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_skid.sv
// N:1 word select feeding a registered 2-entry skid stage with valid/ready.
// Define PIPE_MUX_SEL_CHECK_EN to zero out-of-range selects and flag sel_err.
module pipe_mux_skid #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
`ifdef PIPE_MUX_SEL_CHECK_EN
  output logic                    sel_err,
`endif
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [WIDTH-1:0] sel_word;
  logic             accept;
  logic             pop;

`ifdef PIPE_MUX_SEL_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);
  logic sel_oor;
  logic err_q, err_d;
  assign sel_oor = {1'b0, sel} >= NUM_IN_W;
  assign sel_err = err_q;
`endif

  // Word 0 is the fallback for any select that matches no input.
  always_comb begin
    sel_word = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
`ifdef PIPE_MUX_SEL_CHECK_EN
    if (sel_oor) sel_word = '0;
`endif
  end

  assign in_ready  = (state_q != TWO) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
`ifdef PIPE_MUX_SEL_CHECK_EN
    err_d   = err_q;
`endif
    if (flush) begin
      state_d = EMPTY;
`ifdef PIPE_MUX_SEL_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = sel_word;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = sel_word;
          end else if (accept) begin
            skid_d  = sel_word;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
`ifdef PIPE_MUX_SEL_CHECK_EN
      if (accept && sel_oor) err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
`ifdef PIPE_MUX_SEL_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
`ifdef PIPE_MUX_SEL_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_mux_skid.sv
// Scoreboard bench for pipe_mux_skid: NUM_IN=4 main instance,
// NUM_IN=3 instance for the out-of-range select case.
module tb_pipe_mux_skid;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, flush, in_valid, out_ready;
  logic [4*W-1:0] in_data;
  logic [1:0]     sel;
  logic           in_ready, out_valid;
  logic [W-1:0]   out_data;

  logic           flush3, in_valid3, out_ready3;
  logic [3*W-1:0] in_data3;
  logic [1:0]     sel3;
  logic           in_ready3, out_valid3;
  logic [W-1:0]   out_data3;
`ifdef PIPE_MUX_SEL_CHECK_EN
  logic           sel_err, sel_err3;
`endif

  pipe_mux_skid #(.WIDTH(W), .NUM_IN(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
`ifdef PIPE_MUX_SEL_CHECK_EN
    .sel_err(sel_err),
`endif
    .out_ready(out_ready)
  );

  pipe_mux_skid #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush3),
    .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3),
`ifdef PIPE_MUX_SEL_CHECK_EN
    .sel_err(sel_err3),
`endif
    .out_ready(out_ready3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [4*W-1:0] d,
                                         input logic [1:0] s);
    logic [W-1:0] w[4];
    for (int k = 0; k < 4; k++) w[k] = d[k*W +: W];
    return w[s];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs settle 1ns after posedge; at negedge we know what the next edge does.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 1);
        else check("sb_data", out_data, sb_q.pop_front());
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_data, sel));
    end
  end

  localparam logic [4*W-1:0] WORDS4 =
    {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  localparam logic [3*W-1:0] WORDS3 =
    {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 2'd0; in_data = WORDS4;
    flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    sel3 = 2'd0; in_data3 = WORDS3;
    #1;

    // reset
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_data3", out_data3, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'b0, in_ready}, 1);

    // single beat, one-cycle latency
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_valid", {31'b0, out_valid}, 1);
    check("lat_data", out_data, 32'hCCCC_0002);
    tick();
    check("lat_drain", {31'b0, out_valid}, 0);

    // fill skid, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    tick();
    sel = 2'd3;
    tick();
    in_valid = 1'b0;
    check("two_in_ready", {31'b0, in_ready}, 0);
    check("two_head", out_data, 32'hBBBB_0001);
    tick();
    check("two_hold", out_data, 32'hBBBB_0001);
    out_ready = 1'b1;
    tick();
    check("skid_head", out_data, 32'hDDDD_0003);
    check("skid_ready", {31'b0, in_ready}, 1);
    tick();
    check("skid_drain", {31'b0, out_valid}, 0);

    // streaming at full rate
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) in_data[k*W +: W] = $urandom;
      sel = 2'(i % 4); in_valid = 1'b1;
      tick();
      check("stream_valid", {31'b0, out_valid}, 1);
      check("stream_ready", {31'b0, in_ready}, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", {31'b0, out_valid}, 0);

    // flush in TWO with a pending beat
    in_data = WORDS4; out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    flush = 1'b1; sel = 2'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_valid", {31'b0, out_valid}, 0);
    check("flush2_ready", {31'b0, in_ready}, 1);
    // flush in ONE while a beat is accepted
    in_valid = 1'b1; sel = 2'd0;
    tick();
    flush = 1'b1; sel = 2'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", {31'b0, out_valid}, 0);
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3;
    tick();
    in_valid = 1'b0;
    check("post_flush", out_data, 32'hDDDD_0003);
    tick();
    check("post_drain", {31'b0, out_valid}, 0);

    // out-of-range select on the NUM_IN=3 instance
    sel3 = 2'd3; in_valid3 = 1'b1;
    tick();
    check("oor_valid", {31'b0, out_valid3}, 1);
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("oor_data", out_data3, 0);
    check("oor_err", {31'b0, sel_err3}, 1);
`else
    check("oor_data", out_data3, 32'h1111_0000);
`endif
    out_ready3 = 1'b1; sel3 = 2'd2;
    tick();
    in_valid3 = 1'b0;
    check("oor_next", out_data3, 32'h3333_0002);
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("oor_sticky", {31'b0, sel_err3}, 1);
`endif
    flush3 = 1'b1;
    tick();
    flush3 = 1'b0;
    check("oor_flush", {31'b0, out_valid3}, 0);
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("oor_err_clr", {31'b0, sel_err3}, 0);
`endif

    tick();
    check("sb_left", 32'(sb_q.size()), 0);
    check("sb_pops", 32'(n_pop), 20);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
